rob: RTL and testbench

- Reorder buffer for the out-of-order RV32I core.
- Sits directly downstream of the reservation station and load/store buffer. It consumes their result broadcasts (ALU and LSB), retires instructions in program order to the register file, and releases stores to the LSB.
- Detects branch mispredicts at commit. On a mispredict it drives the machine-wide rob_clear_up flush and the redirect PC.
- Also serves operand lookups for the issue stage.

---
 rtl/rob.sv | 194 +++++++++++++++++++
 tb/tb_rob.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob.sv
// Reorder buffer: allocates entries in program order, collects ALU/LSB result
// broadcasts, retires in order, and flushes the machine on a branch mispredict.
module rob #(
  parameter int ROB_BIT = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,

  input  logic               issue_valid,
  input  logic [1:0]         issue_type,
  input  logic [4:0]         issue_rd,
  input  logic               issue_done,
  input  logic [31:0]        issue_value,
  input  logic               issue_pred_taken,
  input  logic [31:0]        issue_alt_pc,
  output logic [ROB_BIT-1:0] issue_entry,
  output logic               full,

  input  logic               alu_valid,
  input  logic [ROB_BIT-1:0] alu_entry,
  input  logic [31:0]        alu_value,
  input  logic               lsb_valid,
  input  logic [ROB_BIT-1:0] lsb_entry,
  input  logic [31:0]        lsb_value,

  input  logic [ROB_BIT-1:0] q1_entry,
  input  logic [ROB_BIT-1:0] q2_entry,
  output logic               q1_ready,
  output logic               q2_ready,
  output logic [31:0]        q1_value,
  output logic [31:0]        q2_value,

  output logic               commit_valid,
  output logic [4:0]         commit_rd,
  output logic [31:0]        commit_value,
  output logic [ROB_BIT-1:0] commit_entry,
  output logic               store_commit,
  output logic [ROB_BIT-1:0] store_entry,
  output logic               rob_clear_up,
  output logic [31:0]        redirect_pc,
  output logic               halt
);

  localparam int ROB_SIZE = 1 << ROB_BIT;
  localparam logic [ROB_BIT:0] FULL_COUNT = (ROB_BIT+1)'(ROB_SIZE);

  typedef enum logic [1:0] {
    T_REG    = 2'b00,
    T_STORE  = 2'b01,
    T_BRANCH = 2'b10,
    T_EXIT   = 2'b11
  } rob_type_e;

  // Handshake: an issue is accepted on a rising edge where issue_valid is high,
  // full is low, rdy_in is high and no flush is in progress; issue_entry is the
  // tag assigned to it. Broadcasts are single-cycle and always accepted (no
  // back-pressure) unless the tagged entry is not busy or a flush is in progress.

  logic [ROB_BIT-1:0] r_head;
  logic [ROB_BIT-1:0] r_tail;
  logic [ROB_BIT:0]   r_count;

  logic               r_busy  [ROB_SIZE];
  logic               r_ready [ROB_SIZE];
  rob_type_e          r_type  [ROB_SIZE];
  logic [4:0]         r_rd    [ROB_SIZE];
  logic [31:0]        r_value [ROB_SIZE];
  logic               r_pred  [ROB_SIZE];
  logic [31:0]        r_alt   [ROB_SIZE];

  logic w_issue;
  logic w_alu_wb;
  logic w_lsb_wb;
  logic w_commit;
  logic w_mispredict;
  logic w_q1_alu, w_q1_lsb, w_q2_alu, w_q2_lsb;

  assign full        = (r_count == FULL_COUNT);
  assign issue_entry = r_tail;

  always_comb begin
    w_issue  = rdy_in && issue_valid && !full && !rob_clear_up;
    w_alu_wb = rdy_in && alu_valid && !rob_clear_up && r_busy[alu_entry];
    w_lsb_wb = rdy_in && lsb_valid && !rob_clear_up && r_busy[lsb_entry];
    // Commit looks only at registered ready; same-cycle broadcasts wait a cycle.
    w_commit = rdy_in && !halt && r_busy[r_head] && r_ready[r_head];
    w_mispredict = w_commit && (r_type[r_head] == T_BRANCH) &&
                   (r_value[r_head][0] != r_pred[r_head]);
  end

  always_comb begin
    w_q1_alu = alu_valid && (alu_entry == q1_entry);
    w_q1_lsb = lsb_valid && (lsb_entry == q1_entry);
    w_q2_alu = alu_valid && (alu_entry == q2_entry);
    w_q2_lsb = lsb_valid && (lsb_entry == q2_entry);

    q1_ready = r_busy[q1_entry] && (r_ready[q1_entry] || w_q1_alu || w_q1_lsb);
    q2_ready = r_busy[q2_entry] && (r_ready[q2_entry] || w_q2_alu || w_q2_lsb);

    if (w_q1_lsb)      q1_value = lsb_value;
    else if (w_q1_alu) q1_value = alu_value;
    else               q1_value = r_value[q1_entry];

    if (w_q2_lsb)      q2_value = lsb_value;
    else if (w_q2_alu) q2_value = alu_value;
    else               q2_value = r_value[q2_entry];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_value <= '0;
      commit_entry <= '0;
      store_commit <= 1'b0;
      store_entry  <= '0;
      rob_clear_up <= 1'b0;
      redirect_pc  <= '0;
      halt         <= 1'b0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_busy[i]  <= 1'b0;
        r_ready[i] <= 1'b0;
      end
    end else if (rdy_in) begin
      commit_valid <= 1'b0;
      store_commit <= 1'b0;
      rob_clear_up <= 1'b0;

      if (w_issue) begin
        r_busy[r_tail]  <= 1'b1;
        r_ready[r_tail] <= issue_done;
        r_type[r_tail]  <= rob_type_e'(issue_type);
        r_rd[r_tail]    <= issue_rd;
        r_value[r_tail] <= issue_value;
        r_pred[r_tail]  <= issue_pred_taken;
        r_alt[r_tail]   <= issue_alt_pc;
        r_tail          <= r_tail + ROB_BIT'(1);
      end

      // LSB is applied second so it wins when both target the same entry.
      if (w_alu_wb) begin
        r_value[alu_entry] <= alu_value;
        r_ready[alu_entry] <= 1'b1;
      end
      if (w_lsb_wb) begin
        r_value[lsb_entry] <= lsb_value;
        r_ready[lsb_entry] <= 1'b1;
      end

      r_count <= r_count + (ROB_BIT+1)'(w_issue) - (ROB_BIT+1)'(w_commit);

      if (w_commit) begin
        r_busy[r_head] <= 1'b0;
        r_head         <= r_head + ROB_BIT'(1);
        case (r_type[r_head])
          T_REG: begin
            commit_valid <= 1'b1;
            commit_rd    <= r_rd[r_head];
            commit_value <= r_value[r_head];
            commit_entry <= r_head;
          end
          T_STORE: begin
            store_commit <= 1'b1;
            store_entry  <= r_head;
          end
          T_EXIT:  halt <= 1'b1;
          default: ;
        endcase
      end

      // A mispredict empties the whole buffer, overriding this cycle's issue.
      if (w_mispredict) begin
        rob_clear_up <= 1'b1;
        redirect_pc  <= r_alt[r_head];
        r_head       <= '0;
        r_tail       <= '0;
        r_count      <= '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
          r_busy[i]  <= 1'b0;
          r_ready[i] <= 1'b0;
        end
      end
    end else begin
      commit_valid <= 1'b0;
      store_commit <= 1'b0;
      rob_clear_up <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for the reorder buffer: stimulus pushes expected retire events
// into a queue, a negedge monitor pops and compares every pulse the ROB emits.
module tb_rob;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        issue_valid;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic        issue_done;
  logic [31:0] issue_value;
  logic        issue_pred_taken;
  logic [31:0] issue_alt_pc;
  logic [3:0]  issue_entry;
  logic        full;
  logic        alu_valid;
  logic [3:0]  alu_entry;
  logic [31:0] alu_value;
  logic        lsb_valid;
  logic [3:0]  lsb_entry;
  logic [31:0] lsb_value;
  logic [3:0]  q1_entry, q2_entry;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [3:0]  commit_entry;
  logic        store_commit;
  logic [3:0]  store_entry;
  logic        rob_clear_up;
  logic [31:0] redirect_pc;
  logic        halt;

  int checks = 0;
  int errors = 0;
  logic [43:0] exp_q[$];

  rob #(.ROB_BIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_done(issue_done), .issue_value(issue_value),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .issue_entry(issue_entry), .full(full),
    .alu_valid(alu_valid), .alu_entry(alu_entry), .alu_value(alu_value),
    .lsb_valid(lsb_valid), .lsb_entry(lsb_entry), .lsb_value(lsb_value),
    .q1_entry(q1_entry), .q2_entry(q2_entry),
    .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_entry(commit_entry),
    .store_commit(store_commit), .store_entry(store_entry),
    .rob_clear_up(rob_clear_up), .redirect_pc(redirect_pc), .halt(halt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  // ---------------- expected-event encoders ----------------
  function automatic logic [43:0] exp_reg(input logic [4:0] rd, input logic [31:0] v,
                                          input logic [3:0] e);
    return {3'b100, rd, v, e};
  endfunction

  function automatic logic [43:0] exp_store(input logic [3:0] e);
    return {3'b010, 5'd0, 32'd0, e};
  endfunction

  function automatic logic [43:0] exp_flush(input logic [31:0] pc);
    return {3'b001, 5'd0, pc, 4'd0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    issue_valid = 0; issue_type = 0; issue_rd = 0; issue_done = 0; issue_value = 0;
    issue_pred_taken = 0; issue_alt_pc = 0;
    alu_valid = 0; alu_entry = 0; alu_value = 0;
    lsb_valid = 0; lsb_entry = 0; lsb_value = 0;
    q1_entry = 0; q2_entry = 0;
  endtask

  task automatic do_issue(input logic [1:0] t, input logic [4:0] rd, input logic done,
                          input logic [31:0] v, input logic pred, input logic [31:0] alt);
    issue_valid = 1; issue_type = t; issue_rd = rd; issue_done = done;
    issue_value = v; issue_pred_taken = pred; issue_alt_pc = alt;
    tick();
    issue_valid = 0;
  endtask

  task automatic alu_wb(input logic [3:0] e, input logic [31:0] v);
    alu_valid = 1; alu_entry = e; alu_value = v;
    tick();
    alu_valid = 0;
  endtask

  task automatic lsb_wb(input logic [3:0] e, input logic [31:0] v);
    lsb_valid = 1; lsb_entry = e; lsb_value = v;
    tick();
    lsb_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_in) begin
    logic [43:0] got;
    logic [43:0] exp_v;
    if (commit_valid || store_commit || rob_clear_up) begin
      got = {commit_valid, store_commit, rob_clear_up, 41'd0};
      if (commit_valid)      got[40:0] = {commit_rd, commit_value, commit_entry};
      else if (store_commit) got[40:0] = {5'd0, 32'd0, store_entry};
      else                   got[40:0] = {5'd0, redirect_pc, 4'd0};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse got=%h expected=none", got);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) begin
          errors++;
          $display("FAIL retire_event got=%h expected=%h", got, exp_v);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout expected=finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    clear_inputs();
    rdy_in = 1;
    do_reset();
    check("reset_commit_valid", 32'(commit_valid), 0);
    check("reset_halt", 32'(halt), 0);
    check("reset_full", 32'(full), 0);
    check("reset_issue_entry", 32'(issue_entry), 0);
    check("reset_redirect_pc", redirect_pc, 0);

    // Out-of-order writebacks, in-order commit.
    do_issue(2'b00, 5'd1, 0, 0, 0, 0);
    do_issue(2'b00, 5'd2, 0, 0, 0, 0);
    do_issue(2'b00, 5'd3, 0, 0, 0, 0);
    exp_q.push_back(exp_reg(5'd1, 32'h22, 4'd0));
    exp_q.push_back(exp_reg(5'd2, 32'h33, 4'd1));
    exp_q.push_back(exp_reg(5'd3, 32'h11, 4'd2));
    alu_wb(4'd2, 32'h11);
    alu_wb(4'd0, 32'h22);
    alu_wb(4'd1, 32'h33);
    idle(4);

    // Fill to 16, reject 17th, then commit with simultaneous issue.
    do_reset();
    for (int i = 0; i < 16; i++) do_issue(2'b00, 5'(i + 1), 0, 0, 0, 0);
    check("full_after_16", 32'(full), 1);
    check("tail_after_16", 32'(issue_entry), 0);
    do_issue(2'b00, 5'd20, 1, 32'h77, 0, 0);
    check("tail_after_17th", 32'(issue_entry), 0);
    check("full_after_17th", 32'(full), 1);
    exp_q.push_back(exp_reg(5'd1, 32'h100, 4'd0));
    exp_q.push_back(exp_reg(5'd2, 32'h101, 4'd1));
    alu_wb(4'd0, 32'h100);
    alu_wb(4'd1, 32'h101);
    do_issue(2'b00, 5'd30, 0, 0, 0, 0);
    check("tail_wrap_commit_issue", 32'(issue_entry), 1);
    check("count15_not_full", 32'(full), 0);
    do_issue(2'b00, 5'd31, 0, 0, 0, 0);
    check("refill_full", 32'(full), 1);
    check("refill_tail", 32'(issue_entry), 2);
    idle(3);

    // Branch mispredict flush.
    do_reset();
    do_issue(2'b10, 5'd0, 0, 0, 1, 32'h104);
    do_issue(2'b00, 5'd5, 1, 32'h77, 0, 0);
    do_issue(2'b00, 5'd6, 0, 0, 0, 0);
    exp_q.push_back(exp_flush(32'h104));
    alu_wb(4'd0, 32'h0);
    tick();
    check("flush_pulse_high", 32'(rob_clear_up), 1);
    check("flush_redirect_pc", redirect_pc, 32'h104);
    issue_valid = 1; issue_type = 2'b00; issue_rd = 5'd7; issue_done = 1; issue_value = 32'h99;
    alu_valid = 1; alu_entry = 4'd0; alu_value = 32'h5;
    tick();
    clear_inputs();
    check("flush_one_cycle", 32'(rob_clear_up), 0);
    check("flush_issue_ignored", 32'(issue_entry), 0);
    check("flush_empty", 32'(full), 0);
    q1_entry = 4'd1;
    #1;
    check("flush_dropped_entry", 32'(q1_ready), 0);
    idle(3);

    // Correctly predicted branch retires silently.
    do_issue(2'b10, 5'd0, 0, 0, 0, 32'h200);
    do_issue(2'b00, 5'd4, 1, 32'h44, 0, 0);
    exp_q.push_back(exp_reg(5'd4, 32'h44, 4'd1));
    alu_wb(4'd0, 32'h0);
    idle(4);

    // Operand lookup bypass and same-entry writeback priority.
    do_reset();
    alu_wb(4'd6, 32'h123);
    for (int i = 0; i < 7; i++) do_issue(2'b00, 5'(10 + i), 0, 0, 0, 0);
    q1_entry = 4'd6;
    #1;
    check("q1_nonbusy_wb_ignored", 32'(q1_ready), 0);
    q1_entry = 4'd5;
    #1;
    check("q1_not_ready", 32'(q1_ready), 0);
    alu_valid = 1; alu_entry = 4'd5; alu_value = 32'hDEAD;
    #1;
    check("q1_bypass_ready", 32'(q1_ready), 1);
    check("q1_bypass_value", q1_value, 32'hDEAD);
    tick();
    alu_valid = 0;
    q2_entry = 4'd5;
    #1;
    check("q2_stored_value", q2_value, 32'hDEAD);
    alu_valid = 1; alu_entry = 4'd4; alu_value = 32'hAAAA;
    lsb_valid = 1; lsb_entry = 4'd4; lsb_value = 32'hBBBB;
    q2_entry = 4'd4;
    #1;
    check("q2_lsb_over_alu_bypass", q2_value, 32'hBBBB);
    tick();
    alu_valid = 0; lsb_valid = 0;
    #1;
    check("q2_lsb_stored", q2_value, 32'hBBBB);
    check("q2_ready_stored", 32'(q2_ready), 1);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(exp_reg(5'(10 + i), 32'hA0 + 32'(i), 4'(i)));
    exp_q.push_back(exp_reg(5'd14, 32'hBBBB, 4'd4));
    exp_q.push_back(exp_reg(5'd15, 32'hDEAD, 4'd5));
    exp_q.push_back(exp_reg(5'd16, 32'h66, 4'd6));
    for (int i = 0; i < 4; i++) lsb_wb(4'(i), 32'hA0 + 32'(i));
    lsb_wb(4'd6, 32'h66);
    idle(10);

    // Store release and sticky halt.
    do_reset();
    do_issue(2'b01, 5'd0, 0, 0, 0, 0);
    do_issue(2'b11, 5'd0, 1, 0, 0, 0);
    do_issue(2'b00, 5'd8, 1, 32'h88, 0, 0);
    exp_q.push_back(exp_store(4'd0));
    lsb_wb(4'd0, 32'h0);
    idle(5);
    check("halt_set", 32'(halt), 1);
    idle(3);
    check("halt_sticky", 32'(halt), 1);

    // rdy_in stall, then mid-stream reset.
    do_reset();
    check("reset_clears_halt", 32'(halt), 0);
    check("reset_store_commit", 32'(store_commit), 0);
    do_issue(2'b00, 5'd9, 1, 32'h99, 0, 0);
    rdy_in = 0;
    issue_valid = 1; issue_type = 2'b00; issue_rd = 5'd1; issue_done = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_commit", 32'(commit_valid), 0);
      check("stall_tail_frozen", 32'(issue_entry), 1);
    end
    issue_valid = 0;
    exp_q.push_back(exp_reg(5'd9, 32'h99, 4'd0));
    rdy_in = 1;
    tick();
    check("resume_commit", 32'(commit_valid), 1);
    check("resume_commit_value", commit_value, 32'h99);
    do_issue(2'b00, 5'd20, 1, 32'h20, 0, 0);
    rst_in = 1;
    tick();
    rst_in = 0;
    check("midreset_commit_valid", 32'(commit_valid), 0);
    check("midreset_tail", 32'(issue_entry), 0);
    check("midreset_commit_value", commit_value, 0);
    idle(4);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
